ann_input_sequencer: RTL and testbench

//  Upstream feeder for the fully-connected classifier (400->120->84->10).

---
 rtl/ann_pkg.sv | 14 +
 rtl/ann_stream_flatten.sv | 24 ++
 rtl/ann_input_sequencer.sv | 131 +++++++++++++
 tb/tb_ann_input_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared constants and state encoding for the classifier input sequencer.
package ann_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_FEATURES = 400;
  localparam int DEF_ANN_CYCLES = 403;
  localparam int DEF_CLASS_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/ann_stream_flatten.sv
// Serial-to-parallel register bank: one element written per enabled cycle at wr_idx.
module ann_stream_flatten #(
  parameter int DATA_WIDTH = 32,
  parameter int N_FEATURES = 400,
  parameter int IDX_W      = $clog2(N_FEATURES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH*N_FEATURES-1:0] vec
);
  logic [DATA_WIDTH-1:0] bank [N_FEATURES];

  for (genvar i = 0; i < N_FEATURES; i++) begin : g_elem
    // Each element decodes its own index so the bank stays a flat set of enables.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    bank[i] <= '0;
      else if (wr_en && (wr_idx == IDX_W'(i)))      bank[i] <= wr_data;
    end
    assign vec[DATA_WIDTH*i +: DATA_WIDTH] = bank[i];
  end
endmodule

// File: rtl/ann_input_sequencer.sv
// Collects a feature vector, runs the classifier for a fixed sweep, captures its class.
module ann_input_sequencer
  import ann_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_FEATURES = DEF_N_FEATURES,
  parameter int ANN_CYCLES = DEF_ANN_CYCLES,
  parameter int CLASS_W    = DEF_CLASS_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  input  logic                             abort,
  output logic [DATA_WIDTH*N_FEATURES-1:0] ann_input,
  output logic                             ann_reset,
  input  logic [CLASS_W-1:0]               class_in,
  output logic [CLASS_W-1:0]               class_out,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic                             busy
);
  localparam int FW = $clog2(N_FEATURES);
  localparam int RW = $clog2(ANN_CYCLES);
  localparam logic [FW-1:0] LAST_FILL = FW'(N_FEATURES - 1);
  localparam logic [RW-1:0] LAST_RUN  = RW'(ANN_CYCLES - 1);

  state_t              state, state_n;
  logic [FW-1:0]       fill_cnt, fill_cnt_n;
  logic [RW-1:0]       run_cnt, run_cnt_n;
  logic                in_ready_n, ann_reset_n, result_valid_n, busy_n;
  logic [CLASS_W-1:0]  class_out_n;
  logic                wr_en;

  // An abort on the same edge as a beat discards that beat.
  assign wr_en = (state == FILL) && in_valid && in_ready && !abort;

  ann_stream_flatten #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_FEATURES (N_FEATURES),
    .IDX_W      (FW)
  ) u_flatten (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (fill_cnt),
    .wr_data (in_data),
    .vec     (ann_input)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      run_cnt      <= '0;
      in_ready     <= 1'b0;
      ann_reset    <= 1'b1;
      result_valid <= 1'b0;
      class_out    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      fill_cnt     <= fill_cnt_n;
      run_cnt      <= run_cnt_n;
      in_ready     <= in_ready_n;
      ann_reset    <= ann_reset_n;
      result_valid <= result_valid_n;
      class_out    <= class_out_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n        = state;
    fill_cnt_n     = fill_cnt;
    run_cnt_n      = run_cnt;
    in_ready_n     = in_ready;
    ann_reset_n    = ann_reset;
    result_valid_n = result_valid;
    class_out_n    = class_out;
    busy_n         = busy;
    unique case (state)
      IDLE: begin
        state_n    = FILL;
        in_ready_n = 1'b1;
      end
      FILL: begin
        if (in_valid && in_ready) begin
          if (fill_cnt == LAST_FILL) begin
            // Counter holds at the last index; it is cleared before the next fill.
            state_n     = RUN;
            in_ready_n  = 1'b0;
            ann_reset_n = 1'b0;
            busy_n      = 1'b1;
            run_cnt_n   = '0;
          end else begin
            fill_cnt_n = fill_cnt + FW'(1);
          end
        end
      end
      RUN: begin
        run_cnt_n = run_cnt + RW'(1);
        if (run_cnt == LAST_RUN) begin
          class_out_n    = class_in;
          result_valid_n = 1'b1;
          ann_reset_n    = 1'b1;
          busy_n         = 1'b0;
          state_n        = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_n = 1'b0;
          fill_cnt_n     = '0;
          in_ready_n     = 1'b1;
          state_n        = FILL;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n        = FILL;
      fill_cnt_n     = '0;
      in_ready_n     = 1'b1;
      ann_reset_n    = 1'b1;
      result_valid_n = 1'b0;
      busy_n         = 1'b0;
    end
  end
endmodule

// File: tb/tb_ann_input_sequencer.sv
// Randomized self-checking bench for ann_input_sequencer against an array-based model.
module tb_ann_input_sequencer;
  localparam int DW = 32;
  localparam int N  = 400;
  localparam int AC = 403;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic            abort = 1'b0;
  logic [DW*N-1:0] ann_input;
  logic            ann_reset;
  logic [CW-1:0]   class_in = '0;
  logic [CW-1:0]   class_out;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [N];

  ann_input_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .abort        (abort),
    .ann_input    (ann_input),
    .ann_reset    (ann_reset),
    .class_in     (class_in),
    .class_out    (class_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int vec_mismatch();
    for (int k = 0; k < N; k++)
      if (ann_input[DW*k +: DW] !== model[k]) return k;
    return -1;
  endfunction

  // Offers beats until n are accepted; the model records each accepted element.
  task automatic feed(input int n, input int gap_pct, input bit incr);
    int got = 0;
    int cyc = 0;
    bit acc;
    logic [DW-1:0] d;
    while (got < n && cyc < 5000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      d = incr ? DW'(got) : $urandom;
      in_data = d;
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        model[got] = d;
        got++;
        checks++;
        if (ann_input[DW*(got-1) +: DW] !== d) begin
          failures++;
          $display("FAIL elem_write idx=%0d got=%0h want=%0h", got-1, ann_input[DW*(got-1) +: DW], d);
        end
        checks++;
        if (got < N ? (ann_reset !== 1'b1 || in_ready !== 1'b1)
                    : (ann_reset !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)) begin
          failures++;
          $display("FAIL run_entry beat=%0d ann_reset=%b in_ready=%b busy=%b", got, ann_reset, in_ready, busy);
        end
      end else begin
        checks++;
        if (ann_reset !== 1'b1) begin
          failures++;
          $display("FAIL early_run beats=%0d ann_reset=%b want 1", got, ann_reset);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got < n) begin
      failures++;
      $display("FAIL feed_timeout accepted=%0d want %0d", got, n);
    end
  endtask

  // Runs the classifier sweep; result must appear exactly AC edges after the last beat.
  task automatic run_and_check(input logic [CW-1:0] cls, input bit offer);
    int k = 0;
    bit seen = 0;
    bit bad = 0;
    int mm;
    class_in = cls;
    while (!seen && k < 1000) begin
      in_valid = offer ? 1'($urandom_range(1)) : 1'b0;
      in_data = $urandom;
      tick();
      k++;
      if (result_valid === 1'b1) seen = 1;
      else if (ann_reset !== 1'b0 || busy !== 1'b1) bad = 1;
      if (in_ready !== 1'b0) bad = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (!seen || k != AC) begin
      failures++;
      $display("FAIL run_latency got=%0d want=%0d seen=%0d", k, AC, seen);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL run_levels ann_reset/busy/in_ready wrong during RUN got=1 want=0");
    end
    checks++;
    if (class_out !== cls || ann_reset !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL result class_out=%0d want=%0d ann_reset=%b busy=%b", class_out, cls, ann_reset, busy);
    end
    mm = vec_mismatch();
    checks++;
    if (mm != -1) begin
      failures++;
      $display("FAIL vec_frozen idx=%0d got=%0h want=%0h", mm, ann_input[DW*mm +: DW], model[mm]);
    end
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_release result_valid=%b in_ready=%b want 0/1", result_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || ann_reset !== 1'b1 || result_valid !== 1'b0 ||
        class_out !== '0 || busy !== 1'b0 || ann_input !== '0) begin
      failures++;
      $display("FAIL reset_vals in_ready=%b ann_reset=%b rv=%b cls=%0d busy=%b vec_zero=%b",
               in_ready, ann_reset, result_valid, class_out, busy, ann_input == '0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_to_fill in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_fill_incr();
    int mm;
    feed(N, 0, 1'b1);
    mm = vec_mismatch();
    checks++;
    if (mm != -1) begin
      failures++;
      $display("FAIL fill_incr idx=%0d got=%0h want=%0h", mm, ann_input[DW*mm +: DW], model[mm]);
    end
    run_and_check(4'd7, 1'b0);
  endtask

  task automatic test_done_hold();
    bit bad = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'($urandom_range(1));
      in_data = $urandom;
      tick();
      if (class_out !== 4'd7 || result_valid !== 1'b1 || ann_reset !== 1'b1 || in_ready !== 1'b0) bad = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL done_hold outputs changed in DONE got=1 want=0");
    end
    checks++;
    if (vec_mismatch() != -1) begin
      failures++;
      $display("FAIL done_ignore vector changed got=1 want=0");
    end
    release_result();
  endtask

  task automatic test_gaps();
    feed(N, 50, 1'b0);
    run_and_check(4'($urandom_range(15)), 1'b1);
    release_result();
  endtask

  task automatic test_abort_fill();
    int mm;
    feed(200, 30, 1'b0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || ann_reset !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_fill in_ready=%b ann_reset=%b busy=%b", in_ready, ann_reset, busy);
    end
    checks++;
    if (ann_input[DW*200 +: DW] !== model[200]) begin
      failures++;
      $display("FAIL abort_discard got=%0h want=%0h", ann_input[DW*200 +: DW], model[200]);
    end
    feed(N, 20, 1'b0);
    mm = vec_mismatch();
    checks++;
    if (mm != -1) begin
      failures++;
      $display("FAIL refill idx=%0d got=%0h want=%0h", mm, ann_input[DW*mm +: DW], model[mm]);
    end
    run_and_check(4'd12, 1'b0);
    release_result();
  endtask

  task automatic test_abort_run_reset();
    bit rv_seen = 0;
    feed(N, 0, 1'b0);
    repeat (150) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (ann_reset !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_run ann_reset=%b busy=%b rv=%b in_ready=%b", ann_reset, busy, result_valid, in_ready);
    end
    repeat (500) begin
      tick();
      if (result_valid !== 1'b0) rv_seen = 1;
    end
    checks++;
    if (rv_seen) begin
      failures++;
      $display("FAIL abort_no_result result_valid got=1 want=0");
    end
    feed(N, 10, 1'b0);
    repeat (150) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ann_reset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || result_valid !== 1'b0 || ann_input !== '0) begin
      failures++;
      $display("FAIL async_reset ann_reset=%b busy=%b in_ready=%b rv=%b", ann_reset, busy, in_ready, result_valid);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle in_ready=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_fill in_ready=%b rv=%b want 1/0", in_ready, result_valid);
    end
  endtask

  task automatic test_back_to_back();
    result_ready = 1'b1;
    feed(N, 0, 1'b0);
    run_and_check(4'd5, 1'b0);
    tick();
    checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_one_cycle rv=%b in_ready=%b want 0/1", result_valid, in_ready);
    end
    feed(N, 0, 1'b0);
    run_and_check(4'd3, 1'b0);
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_incr();
    test_done_hold();
    test_gaps();
    test_abort_fill();
    test_abort_run_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
